// File: rtl/pending_encoder_16to4_pkg.sv
// Shared select-encoding types and the line-to-index convention.
// Used by the pending encoder and by the 16:1 select muxes it drives.
package core_sel_pkg;

    typedef enum logic {
        IDLE,
        OFFER
    } enc_state_t;

    // Index i addresses line bit [n-1-i].
    function automatic int idx_to_bit(input int n, input int idx);
        return n - 1 - idx;
    endfunction

endpackage

// File: rtl/pending_encoder_16to4_if.sv
// Valid/ready offer channel carrying the encoded select index.
// The producer drives the master side and the consumer drives the slave side.
interface pending_encoder_16to4_if #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
);
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_ready;

    modport master (
        output out_valid,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/pending_encoder_16to4_prio_pick.sv
// Rotating priority search: first set index at or after i_start, wrapping.
// Index i is looked up at vector bit [N-1-i].
module prio_pick_16
    import core_sel_pkg::*;
#(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_vec,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_j;

    // Scan farthest-first so the nearest hit overwrites the result.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = i_start + IDX_W'(k);
            if (i_vec[IDX_W'(idx_to_bit(N, int'(w_j)))]) begin
                o_found = 1'b1;
                o_idx   = w_j;
            end
        end
    end

endmodule

// File: rtl/pending_encoder_16to4.sv
// Sticky request collector that offers one pending line index over valid/ready.
// Define PENDING_ENC_ROUND_ROBIN_EN for rotating priority; default is lowest index first.
module pending_encoder_16to4
    import core_sel_pkg::*;
#(
    parameter  int N     = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N-1:0]                   req,
    input  logic                           flush,
    pending_encoder_16to4_if.master        sel,
    output logic [N-1:0]                   pending
);

    enc_state_t       r_state;
    logic [N-1:0]     r_pending;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;

    logic             w_hs;
    logic [N-1:0]     w_clr;
    logic [N-1:0]     w_rem;
    logic [IDX_W-1:0] w_start;
    logic             w_found;
    logic [IDX_W-1:0] w_pick;

    assign w_hs = r_valid && sel.out_ready;

    always_comb begin
        w_clr = '0;
        if (w_hs) begin
            w_clr[IDX_W'(idx_to_bit(N, int'(r_idx)))] = 1'b1;
        end
    end

    // Same-cycle requests are excluded from the pick; they are seen next cycle.
    assign w_rem = r_pending & ~w_clr;

`ifdef PENDING_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_rr_ptr;

    assign w_start = w_hs ? r_idx + 1'b1 : r_rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= r_idx + 1'b1;
        end
    end
`else
    assign w_start = '0;
`endif

    prio_pick_16 #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_vec   (w_rem),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
        end else if (flush) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_pending <= w_rem | req;
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_idx   <= w_pick;
                        r_valid <= 1'b1;
                        r_state <= OFFER;
                    end
                end
                OFFER: begin
                    if (w_hs) begin
                        if (w_found) begin
                            r_idx <= w_pick;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sel.out_valid = r_valid;
    assign sel.out_idx   = r_idx;
    assign pending       = r_pending;

endmodule

// File: tb/tb_pending_encoder_16to4.sv
// Bench for pending_encoder_16to4: directed table, hand sequences, random vs model.
// Honours PENDING_ENC_ROUND_ROBIN_EN in its reference model.
module tb_pending_encoder_16to4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] req;
    logic [15:0] pending;

    int n_vec = 0;
    int n_err = 0;

    pending_encoder_16to4_if #(.N(16)) sel ();

    pending_encoder_16to4 dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .flush   (flush),
        .sel     (sel),
        .pending (pending)
    );

    always #5 clk = ~clk;

    // Reference model, kept per index (index i = line bit 15-i).
    bit m_pend [16];
    bit m_valid;
    int m_idx;
`ifdef PENDING_ENC_ROUND_ROBIN_EN
    int m_ptr;
`endif

    function automatic logic [15:0] m_pend_vec();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 16; i++)
            if (m_pend[i]) v = v | (16'(1) << (15 - i));
        return v;
    endfunction

    function automatic bit req_has(input logic [15:0] r, input int i);
        return ((r >> (15 - i)) & 16'(1)) != 0;
    endfunction

    task automatic model_update(input logic [15:0] r, input bit f,
                                input bit rd, input bit rs);
        bit hs;
        bit rem [16];
        int start;
        bit found;
        int pick;
        if (rs) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_valid = 1'b0;
            m_idx   = 0;
`ifdef PENDING_ENC_ROUND_ROBIN_EN
            m_ptr   = 0;
`endif
        end else begin
            hs = m_valid && rd;
            for (int i = 0; i < 16; i++)
                rem[i] = m_pend[i] && !(hs && i == m_idx);
`ifdef PENDING_ENC_ROUND_ROBIN_EN
            start = hs ? (m_idx + 1) % 16 : m_ptr;
            if (hs) m_ptr = (m_idx + 1) % 16;
`else
            start = 0;
`endif
            for (int i = 0; i < 16; i++)
                m_pend[i] = f ? 1'b0 : (rem[i] || req_has(r, i));
            if (f) begin
                m_valid = 1'b0;
            end else if (!m_valid || hs) begin
                found = 1'b0;
                pick  = 0;
                for (int k = 0; k < 16; k++) begin
                    if (!found && rem[(start + k) % 16]) begin
                        found = 1'b1;
                        pick  = (start + k) % 16;
                    end
                end
                m_valid = found;
                if (found) m_idx = pick;
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // One clock: drive, advance model, then sample 1ns after the edge.
    task automatic step(input logic [15:0] r, input bit f,
                        input bit rd, input bit rs);
        req           = r;
        flush         = f;
        sel.out_ready = rd;
        reset         = rs;
        @(posedge clk);
        model_update(r, f, rd, rs);
        #1;
        n_vec++;
        chk("model_valid", int'(sel.out_valid), int'(m_valid));
        chk("model_pending", int'(pending), int'(m_pend_vec()));
        if (m_valid) chk("model_idx", int'(sel.out_idx), m_idx);
    endtask

    typedef struct {
        logic [15:0] req;
        bit          flush;
        bit          rdy;
        bit          rst;
        bit          ev;
        int          ei;
        logic [15:0] ep;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] r, input bit f,
                                input bit rd, input bit rs, input bit ev,
                                input int ei, input logic [15:0] ep);
        vec_t v;
        v.req = r; v.flush = f; v.rdy = rd; v.rst = rs;
        v.ev = ev; v.ei = ei; v.ep = ep;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        logic [15:0] r;
        bit          f, rd, rs;

        req = '0; flush = 1'b0; reset = 1'b1; sel.out_ready = 1'b0;

        // Single request, then backpressure on idx 0 and 15.
        tbl.push_back(mk(16'h0000, 0, 0, 1, 0, 0, 16'h0000));
        tbl.push_back(mk(16'h0400, 0, 1, 0, 0, 0, 16'h0400));
        tbl.push_back(mk(16'h0000, 0, 1, 0, 1, 5, 16'h0400));
        tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(16'h0000, 0, 0, 1, 0, 0, 16'h0000));
        tbl.push_back(mk(16'h8001, 0, 0, 0, 0, 0, 16'h8001));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(16'h0000, 0, 0, 0, 1, 0, 16'h8001));
        tbl.push_back(mk(16'h0000, 0, 1, 0, 1, 15, 16'h0001));
        tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(16'h0000, 0, 0, 0, 0, 0, 16'h0000));

        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].flush, tbl[i].rdy, tbl[i].rst);
            chk($sformatf("tbl%0d_valid", i), int'(sel.out_valid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_pend", i), int'(pending), int'(tbl[i].ep));
            if (tbl[i].ev || tbl[i].rst)
                chk($sformatf("tbl%0d_idx", i), int'(sel.out_idx), tbl[i].ei);
        end

        // Set-wins collision on idx 3 (bit 12).
        step(16'h0000, 0, 0, 1);
        step(16'h1000, 0, 0, 0);
        step(16'h0000, 0, 0, 0);
        chk("sw_offer_idx", int'(sel.out_idx), 3);
        step(16'h1000, 0, 1, 0);
        chk("sw_kept_pend", int'(pending), 16'h1000);
        step(16'h0000, 0, 0, 0);
        chk("sw_reoffer_valid", int'(sel.out_valid), 1);
        chk("sw_reoffer_idx", int'(sel.out_idx), 3);

        // Flush and reset mid-offer with everything pending.
        step(16'hFFFF, 0, 0, 0);
        step(16'h0000, 0, 0, 0);
        chk("fl_pre_valid", int'(sel.out_valid), 1);
        step(16'h0000, 1, 1, 0);
        chk("fl_valid", int'(sel.out_valid), 0);
        chk("fl_pend", int'(pending), 0);
        step(16'hFFFF, 0, 0, 0);
        step(16'h0000, 0, 0, 0);
        step(16'h0000, 0, 1, 1);
        chk("rs_valid", int'(sel.out_valid), 0);
        chk("rs_pend", int'(pending), 0);
        chk("rs_idx", int'(sel.out_idx), 0);

        // Full drain: 16 grants on 16 consecutive cycles.
        step(16'hFFFF, 0, 1, 0);
        chk("fd_valid0", int'(sel.out_valid), 0);
        for (int k = 0; k < 16; k++) begin
            step(16'h0000, 0, 1, 0);
            chk($sformatf("fd_valid_%0d", k), int'(sel.out_valid), 1);
            chk($sformatf("fd_idx_%0d", k), int'(sel.out_idx), k);
        end
        step(16'h0000, 0, 1, 0);
        chk("fd_done_valid", int'(sel.out_valid), 0);
        chk("fd_done_pend", int'(pending), 0);

        // Idx 2 and 9 requested continuously with the consumer always ready.
        step(16'h0000, 0, 0, 1);
        for (int k = 0; k < 10; k++) step(16'h2040, 0, 1, 0);
        step(16'h0000, 0, 0, 1);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            r  = ($urandom_range(0, 2) == 0) ? 16'($urandom) & 16'($urandom) : 16'h0;
            f  = ($urandom_range(0, 40) == 0);
            rd = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 80) == 0);
            step(r, f, rd, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
